if_stage: RTL and testbench

PC-generation and instruction-fetch stage of the five-stage MIPS pipeline; it issues instruction-SRAM reads and feeds the decode stage. It consumes the branch bus driven by decode, honours the global stall vector, and buffers a taken branch that arrives while fetch is stalled. Its output bus `{ce, pc}` is what decode registers each unstalled cycle.

---
 rtl/if_stage.sv | 81 ++++++++
 tb/tb_if_stage.sv | 128 ++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage -- PC generation and instruction fetch for the five-stage MIPS pipe.
//
// Issues instruction-SRAM reads and hands {ce, pc} to decode. A taken branch
// from decode redirects the next PC in the same cycle; a branch that arrives
// while this stage is stalled is parked in a one-entry buffer and replayed on
// the first unstalled edge.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall[StallBus]   pipeline stall vector, bit 0 freezes PC/CE
//   br_bus[32:0]      {br_e, br_addr} from decode (combinational)
//   if_to_id_bus      {ce, pc} to decode
//   inst_sram_*       instruction SRAM read port (never writes)
//   fetch_adel        misaligned-fetch flag for the exception path
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
  parameter int          StallBus = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [StallBus-1:0] stall,
  input  logic [32:0]         br_bus,
  output logic [32:0]         if_to_id_bus,
  output logic                inst_sram_en,
  output logic [3:0]          inst_sram_wen,
  output logic [31:0]         inst_sram_addr,
  output logic [31:0]         inst_sram_wdata,
  output logic                fetch_adel
);

  localparam logic Stop = 1'b1;

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_r, pc_next, pend_addr;
  logic        ce_r, pend_v;
  logic        stalled;

  assign {br_e, br_addr} = br_bus;
  assign stalled         = (stall[0] == Stop);

  // Only bit 0 matters here; the rest of the vector belongs to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[StallBus-1:1];

  // A live branch beats a buffered one: decode only raises br_e for the
  // newest branch, so anything still pending is stale by then.
  always_comb begin
    pc_next = pc_r + 32'd4;
    if (br_e)        pc_next = br_addr;
    else if (pend_v) pc_next = pend_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r      <= RESET_PC;
      ce_r      <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'd0;
    end else if (stalled) begin
      // PC/CE freeze; latest branch seen during the stall wins the buffer.
      if (br_e) begin
        pend_v    <= 1'b1;
        pend_addr <= br_addr;
      end
    end else begin
      ce_r   <= 1'b1;
      pc_r   <= pc_next;
      pend_v <= 1'b0;
    end
  end

  assign if_to_id_bus    = {ce_r, pc_r};
  assign inst_sram_en    = ce_r;
  assign inst_sram_addr  = pc_r;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;
  // Misaligned targets are fetched as-is; the exception path decides.
  assign fetch_adel      = ce_r & (pc_r[1:0] != 2'b00);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step drives stall/branch inputs, pushes
// the expected post-edge {ce, pc, adel} to a scoreboard queue, clocks once,
// then pops and compares against the DUT outputs.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        fetch_adel;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .fetch_adel      (fetch_adel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_n, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be after it.
  task automatic step(input logic r, input logic s0, input logic be,
                      input logic [31:0] ba, input logic ece,
                      input logic [31:0] epc, input logic eadel);
    exp_t e;
    rst    = r;
    stall  = {5'b0, s0};
    br_bus = {be, ba};
    e.ce = ece; e.pc = epc; e.adel = eadel;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step_n++;
    e = exp_q.pop_front();
    chk("pc",    if_to_id_bus[31:0], e.pc);
    chk("ce",    {31'd0, if_to_id_bus[32]}, {31'd0, e.ce});
    chk("addr",  inst_sram_addr, e.pc);
    chk("en",    {31'd0, inst_sram_en}, {31'd0, e.ce});
    chk("adel",  {31'd0, fetch_adel}, {31'd0, e.adel});
    chk("wen",   {28'd0, inst_sram_wen}, 32'd0);
    chk("wdata", inst_sram_wdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = '0; br_bus = '0;

    // Reset state, including a stall asserted during reset.
    step(1, 0, 0, 32'h0,         0, 32'hBFBF_FFFC, 0);
    step(1, 1, 1, 32'hBFC0_0700, 0, 32'hBFBF_FFFC, 0);
    step(1, 0, 0, 32'h0,         0, 32'hBFBF_FFFC, 0);

    // Sequential fetch from the boot vector.
    step(0, 0, 0, 32'h0, 1, 32'hBFC0_0000, 0);
    step(0, 0, 0, 32'h0, 1, 32'hBFC0_0004, 0);
    step(0, 0, 0, 32'h0, 1, 32'hBFC0_0008, 0);

    // Unstalled redirect.
    step(0, 0, 1, 32'hBFC0_0100, 1, 32'hBFC0_0100, 0);
    step(0, 0, 0, 32'h0,         1, 32'hBFC0_0104, 0);

    // Branch during a 3-cycle stall is buffered and replayed once.
    step(0, 1, 1, 32'hBFC0_0200, 1, 32'hBFC0_0104, 0);
    step(0, 1, 0, 32'h0,         1, 32'hBFC0_0104, 0);
    step(0, 1, 0, 32'h0,         1, 32'hBFC0_0104, 0);
    step(0, 0, 0, 32'h0,         1, 32'hBFC0_0200, 0);
    step(0, 0, 0, 32'h0,         1, 32'hBFC0_0204, 0);

    // Live branch on the first unstalled cycle beats the buffered one.
    step(0, 1, 1, 32'hBFC0_0300, 1, 32'hBFC0_0204, 0);
    step(0, 0, 1, 32'hBFC0_0400, 1, 32'hBFC0_0400, 0);
    step(0, 0, 0, 32'h0,         1, 32'hBFC0_0404, 0);

    // A later branch in the same stall overwrites the buffer.
    step(0, 1, 1, 32'hBFC0_0500, 1, 32'hBFC0_0404, 0);
    step(0, 1, 1, 32'hBFC0_0600, 1, 32'hBFC0_0404, 0);
    step(0, 0, 0, 32'h0,         1, 32'hBFC0_0600, 0);
    step(0, 0, 0, 32'h0,         1, 32'hBFC0_0604, 0);

    // Misaligned target fetched as-is and flagged.
    step(0, 0, 1, 32'hBFC0_0102, 1, 32'hBFC0_0102, 1);
    step(0, 0, 0, 32'h0,         1, 32'hBFC0_0106, 1);
    step(0, 0, 1, 32'hBFC0_1000, 1, 32'hBFC0_1000, 0);

    // 32-bit wrap of pc + 4.
    step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 32'h0,         1, 32'h0000_0000, 0);

    // Reset mid-stall with a pending branch drops it.
    step(0, 1, 1, 32'hBFC0_0700, 1, 32'h0000_0000, 0);
    step(1, 1, 0, 32'h0,         0, 32'hBFBF_FFFC, 0);
    step(0, 0, 0, 32'h0,         1, 32'hBFC0_0000, 0);
    step(0, 0, 0, 32'h0,         1, 32'hBFC0_0004, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
